// File: rtl/led_zone_mean.sv
// led_zone_mean: accumulates a raster RGB pixel stream into horizontal zones and,
// once a full frame has been seen, publishes a 4-bit mean colour per zone together
// with a one-cycle start pulse for the downstream LED refresh controller.
module led_zone_mean #(
    parameter int ZONES       = 8,
    parameter int ZONE_W_LOG2 = 3,
    parameter int LINES_LOG2  = 2
) (
    input  logic       clk_fast,
    input  logic       rst,
    input  logic       en,
    input  logic       sof,
    input  logic       pix_valid,
    input  logic [7:0] pix_r,
    input  logic [7:0] pix_g,
    input  logic [7:0] pix_b,
    output logic [3:0] MeanR [ZONES],
    output logic [3:0] MeanG [ZONES],
    output logic [3:0] MeanB [ZONES],
    output logic       start,
    output logic       busy,
    output logic       frame_err
);

    // Sum of 2^(ZONE_W_LOG2+LINES_LOG2) 8-bit samples always fits in ACC_W bits.
    localparam int ACC_W  = 8 + ZONE_W_LOG2 + LINES_LOG2;
    localparam int ZIDX_W = (ZONES > 1) ? $clog2(ZONES) : 1;
    localparam int X_W    = ZIDX_W + ZONE_W_LOG2;
    localparam int Y_W    = (LINES_LOG2 > 0) ? LINES_LOG2 : 1;

    localparam logic [X_W-1:0] X_LAST = X_W'((ZONES << ZONE_W_LOG2) - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'((1 << LINES_LOG2) - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [ACC_W-1:0] accR_q [ZONES];
    logic [ACC_W-1:0] accG_q [ZONES];
    logic [ACC_W-1:0] accB_q [ZONES];
    logic [ACC_W-1:0] accR_d [ZONES];
    logic [ACC_W-1:0] accG_d [ZONES];
    logic [ACC_W-1:0] accB_d [ZONES];
    logic [3:0]       meanR_q [ZONES];
    logic [3:0]       meanG_q [ZONES];
    logic [3:0]       meanB_q [ZONES];
    logic [3:0]       meanR_d [ZONES];
    logic [3:0]       meanG_d [ZONES];
    logic [3:0]       meanB_d [ZONES];
    logic             start_q, start_d;
    logic             frameErr_q, frameErr_d;

    logic             pixAccept;
    logic             restart;
    logic [ZIDX_W-1:0] zoneIdx;

    // Outside an active frame only a start-of-frame pixel is taken; DONE takes nothing.
    assign pixAccept = pix_valid & en &
                       ((state_q == ST_ACCUM) | (sof & (state_q == ST_IDLE)));
    assign restart   = pixAccept & sof;
    assign zoneIdx   = ZIDX_W'(x_q >> ZONE_W_LOG2);

    // Next-state logic: frame (re)start, per-pixel accumulation, and mean publication.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        accR_d     = accR_q;
        accG_d     = accG_q;
        accB_d     = accB_q;
        meanR_d    = meanR_q;
        meanG_d    = meanG_q;
        meanB_d    = meanB_q;
        start_d    = 1'b0;
        frameErr_d = 1'b0;

        if (restart) begin
            // A sof seen mid-frame throws the partial frame away and flags it.
            frameErr_d = (state_q == ST_ACCUM);
            for (int z = 0; z < ZONES; z++) begin
                accR_d[z] = '0;
                accG_d[z] = '0;
                accB_d[z] = '0;
            end
            accR_d[0] = ACC_W'(pix_r);
            accG_d[0] = ACC_W'(pix_g);
            accB_d[0] = ACC_W'(pix_b);
            x_d       = X_W'(1);
            y_d       = '0;
            state_d   = ST_ACCUM;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_ACCUM: begin
                    if (!en) begin
                        state_d = ST_IDLE;
                    end else if (pixAccept) begin
                        accR_d[zoneIdx] = accR_q[zoneIdx] + ACC_W'(pix_r);
                        accG_d[zoneIdx] = accG_q[zoneIdx] + ACC_W'(pix_g);
                        accB_d[zoneIdx] = accB_q[zoneIdx] + ACC_W'(pix_b);
                        if (x_q == X_LAST) begin
                            x_d = '0;
                            if (y_q == Y_LAST) begin
                                state_d = ST_DONE;
                            end else begin
                                y_d = y_q + 1'b1;
                            end
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    for (int z = 0; z < ZONES; z++) begin
                        meanR_d[z] = accR_q[z][ACC_W-1 -: 4];
                        meanG_d[z] = accG_q[z][ACC_W-1 -: 4];
                        meanB_d[z] = accB_q[z][ACC_W-1 -: 4];
                    end
                    start_d = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters, accumulators and published means, all cleared by reset.
    always_ff @(posedge clk_fast) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            start_q    <= 1'b0;
            frameErr_q <= 1'b0;
            for (int z = 0; z < ZONES; z++) begin
                accR_q[z]  <= '0;
                accG_q[z]  <= '0;
                accB_q[z]  <= '0;
                meanR_q[z] <= '0;
                meanG_q[z] <= '0;
                meanB_q[z] <= '0;
            end
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            start_q    <= start_d;
            frameErr_q <= frameErr_d;
            accR_q     <= accR_d;
            accG_q     <= accG_d;
            accB_q     <= accB_d;
            meanR_q    <= meanR_d;
            meanG_q    <= meanG_d;
            meanB_q    <= meanB_d;
        end
    end

    assign MeanR     = meanR_q;
    assign MeanG     = meanG_q;
    assign MeanB     = meanB_q;
    assign start     = start_q;
    assign frame_err = frameErr_q;
    assign busy      = (state_q == ST_ACCUM);

endmodule
